// File: rtl/axi_stream_width_upsizer_if.sv
// -----------------------------------------------------------------------------
// axi_stream_width_upsizer_if
//   Handshake bundle for the narrow-to-wide AXI-Stream packer. It carries both
//   the narrow input stream and the wide output stream of one packer instance.
//
//   Signals
//     s_valid_i / s_data_i / s_last_i / s_ready_o : narrow input stream
//     m_valid_o / m_data_o / m_last_o / m_fill_o / m_ready_i : wide output stream
//
//   Modports
//     slave  : the packer's view (consumes the narrow stream, produces the wide one)
//     master : the surrounding logic's view (feeds beats, absorbs words)
// -----------------------------------------------------------------------------
interface axi_stream_width_upsizer_if #(
   parameter int INPUT_WIDTH  = 1,
   parameter int OUTPUT_WIDTH = 8
);
   localparam int RATIO  = OUTPUT_WIDTH / INPUT_WIDTH;
   localparam int FILL_W = $clog2(RATIO + 1);

   logic                    s_valid_i;
   logic [INPUT_WIDTH-1:0]  s_data_i;
   logic                    s_last_i;
   logic                    s_ready_o;
   logic                    m_ready_i;
   logic                    m_valid_o;
   logic [OUTPUT_WIDTH-1:0] m_data_o;
   logic                    m_last_o;
   logic [FILL_W-1:0]       m_fill_o;

   modport slave (
      input  s_valid_i, s_data_i, s_last_i, m_ready_i,
      output s_ready_o, m_valid_o, m_data_o, m_last_o, m_fill_o
   );

   modport master (
      output s_valid_i, s_data_i, s_last_i, m_ready_i,
      input  s_ready_o, m_valid_o, m_data_o, m_last_o, m_fill_o
   );
endinterface

// File: rtl/axi_stream_width_upsizer.sv
// -----------------------------------------------------------------------------
// axi_stream_width_upsizer
//   Gathers RATIO = OUTPUT_WIDTH/INPUT_WIDTH narrow beats into one wide word.
//   A beat flagged last closes the word early; the remaining slots are zero and
//   m_fill_o reports how many beats the word holds (1..RATIO).
//
//   Ports
//     clk    : rising-edge clock
//     resetn : synchronous active-low reset; drops any partial word
//     bus    : axi_stream_width_upsizer_if.slave
//              s_valid_i/s_data_i/s_last_i in, s_ready_o out  (narrow side)
//              m_valid_o/m_data_o/m_last_o/m_fill_o out, m_ready_i in (wide side)
//
//   Parameters
//     INPUT_WIDTH  : bits per input beat
//     OUTPUT_WIDTH : bits per output word (multiple of INPUT_WIDTH, larger)
//     MSB_FIRST    : 1 = first beat in the word MSBs, 0 = first beat in the LSBs
// -----------------------------------------------------------------------------
module axi_stream_width_upsizer #(
   parameter int INPUT_WIDTH  = 1,
   parameter int OUTPUT_WIDTH = 8,
   parameter bit MSB_FIRST    = 1'b1
) (
   input logic                        clk,
   input logic                        resetn,
   axi_stream_width_upsizer_if.slave  bus
);
   localparam int RATIO  = OUTPUT_WIDTH / INPUT_WIDTH;
   localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int FILL_W = $clog2(RATIO + 1);

   generate
      if ((OUTPUT_WIDTH % INPUT_WIDTH) != 0 || OUTPUT_WIDTH <= INPUT_WIDTH) begin : g_bad_width
         $error("axi_stream_width_upsizer: OUTPUT_WIDTH must be a larger multiple of INPUT_WIDTH");
      end
   endgenerate

   // Moves one beat into its slot of an otherwise zero word.
   function automatic logic [OUTPUT_WIDTH-1:0] place_beat(
      input logic [INPUT_WIDTH-1:0] d,
      input logic [CNT_W-1:0]       k
   );
      int slot;
      slot = MSB_FIRST ? (RATIO - 1 - int'(k)) : int'(k);
      return OUTPUT_WIDTH'(d) << (slot * INPUT_WIDTH);
   endfunction

   logic [CNT_W-1:0]        count_q;
   logic [OUTPUT_WIDTH-1:0] acc_q;
   logic                    m_valid_q;
   logic [OUTPUT_WIDTH-1:0] m_data_q;
   logic                    m_last_q;
   logic [FILL_W-1:0]       m_fill_q;

   logic                    s_ready;
   logic                    s_acc;
   logic                    m_acc;
   logic                    complete;
   logic [OUTPUT_WIDTH-1:0] acc_with_beat;

   // The output register is refilled on the same edge it is emptied, so the
   // input may proceed whenever the register is empty or being taken.
   assign s_ready       = ~m_valid_q | bus.m_ready_i;
   assign s_acc         = bus.s_valid_i & s_ready;
   assign m_acc         = m_valid_q & bus.m_ready_i;
   assign complete      = s_acc & (bus.s_last_i | (count_q == CNT_W'(RATIO - 1)));
   // Unfilled slots of acc_q are always zero, so OR-ing in the beat is enough.
   assign acc_with_beat = acc_q | place_beat(bus.s_data_i, count_q);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_q   <= '0;
         acc_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_fill_q  <= '0;
      end else if (complete) begin
         // A completing beat can only be accepted when the output register is
         // free, so loading it here never overwrites an untaken word.
         m_valid_q <= 1'b1;
         m_data_q  <= acc_with_beat;
         m_last_q  <= bus.s_last_i;
         m_fill_q  <= FILL_W'(count_q) + FILL_W'(1);
         acc_q     <= '0;
         count_q   <= '0;
      end else begin
         if (s_acc) begin
            acc_q   <= acc_with_beat;
            count_q <= count_q + CNT_W'(1);
         end
         // Data/last/fill keep their last value after the word is taken.
         if (m_acc) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign bus.s_ready_o = s_ready;
   assign bus.m_valid_o = m_valid_q;
   assign bus.m_data_o  = m_data_q;
   assign bus.m_last_o  = m_last_q;
   assign bus.m_fill_o  = m_fill_q;
endmodule

// File: tb/tb_axi_stream_width_upsizer.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_width_upsizer
//   Two packers (MSB-first and LSB-first) share one input stream and one
//   downstream ready. A queue-based frame model predicts every word for both
//   packings; a monitor pops and compares on each output handshake.
// -----------------------------------------------------------------------------
module tb_axi_stream_width_upsizer;
   localparam int IW    = 1;
   localparam int OW    = 8;
   localparam int RATIO = OW / IW;
   localparam int FW    = $clog2(RATIO + 1);

   typedef struct {
      logic [OW-1:0] data;
      logic [FW-1:0] fill;
      logic          last;
   } word_t;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   axi_stream_width_upsizer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) if_msb ();
   axi_stream_width_upsizer_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) if_lsb ();

   axi_stream_width_upsizer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .resetn(resetn), .bus(if_msb)
   );
   axi_stream_width_upsizer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .resetn(resetn), .bus(if_lsb)
   );

   assign if_lsb.s_valid_i = if_msb.s_valid_i;
   assign if_lsb.s_data_i  = if_msb.s_data_i;
   assign if_lsb.s_last_i  = if_msb.s_last_i;
   assign if_lsb.m_ready_i = if_msb.m_ready_i;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    cyc      = 0;
   bit    ready_val = 1'b1;
   bit    rand_rdy  = 1'b0;
   bit    gap_mode  = 1'b0;
   int    last_acc  = -1;

   logic [IW-1:0] cur[$];
   word_t         exp_q[2][$];

   logic          mv[2];
   logic [OW-1:0] md[2];
   logic [FW-1:0] mf[2];
   logic          ml[2];
   assign mv[0] = if_msb.m_valid_o; assign md[0] = if_msb.m_data_o;
   assign mf[0] = if_msb.m_fill_o;  assign ml[0] = if_msb.m_last_o;
   assign mv[1] = if_lsb.m_valid_o; assign md[1] = if_lsb.m_data_o;
   assign mf[1] = if_lsb.m_fill_o;  assign ml[1] = if_lsb.m_last_o;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if_msb.m_ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : ready_val;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference packing: beat k of a word sits k slots from the leading edge.
   function automatic void close_word(input logic last);
      word_t wm, wl;
      wm.data = '0;
      wl.data = '0;
      foreach (cur[k]) begin
         wm.data = wm.data | (OW'(cur[k]) << (OW - (k + 1) * IW));
         wl.data = wl.data | (OW'(cur[k]) << (k * IW));
      end
      wm.fill = FW'(cur.size());
      wl.fill = wm.fill;
      wm.last = last;
      wl.last = last;
      exp_q[0].push_back(wm);
      exp_q[1].push_back(wl);
      cur.delete();
   endfunction

   function automatic void model_accept(input logic [IW-1:0] d, input logic l);
      cur.push_back(d);
      if (l || cur.size() == RATIO) close_word(l);
   endfunction

   task automatic send_beat(input logic [IW-1:0] d, input logic l);
      bit taken  = 1'b0;
      int budget = 0;
      if_msb.s_valid_i = 1'b1;
      if_msb.s_data_i  = d;
      if_msb.s_last_i  = l;
      while (!taken) begin
         @(negedge clk);
         if (if_msb.s_ready_o) begin
            taken = 1'b1;
            model_accept(d, l);
         end
         @(posedge clk);
         #1;
         budget++;
         if (!taken && budget > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready_o stayed 0 for %0d cycles, expected acceptance", budget);
            taken = 1'b1;
         end
      end
      if_msb.s_valid_i = 1'b0;
      if_msb.s_last_i  = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] pat, input bit last_on_final);
      for (int i = 0; i < 8; i++) send_beat(pat[7-i], last_on_final && (i == 7));
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 300) begin
         @(posedge clk);
         t++;
      end
      check("drain_timeout", 64'(t >= 300), 64'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      cur.delete();
      exp_q[0].delete();
      exp_q[1].delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_m_valid", 64'(if_msb.m_valid_o), 64'd0);
      check("rst_m_data",  64'(if_msb.m_data_o),  64'd0);
      check("rst_m_fill",  64'(if_msb.m_fill_o),  64'd0);
      check("rst_m_last",  64'(if_msb.m_last_o),  64'd0);
      check("rst_s_ready", 64'(if_msb.s_ready_o), 64'd1);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   // Monitor: compares on every output handshake and checks hold while stalled.
   bit    stall[2];
   word_t held[2];
   always @(negedge clk) begin
      if (!resetn) begin
         stall[0] = 1'b0;
         stall[1] = 1'b0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (stall[d]) begin
               check($sformatf("hold_dut%0d", d), 64'({mv[d], md[d], mf[d], ml[d]}),
                     64'({1'b1, held[d].data, held[d].fill, held[d].last}));
            end
            if (mv[d] && if_msb.m_ready_i) begin
               if (exp_q[d].size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word_dut%0d: got data %0h fill %0d, expected no word", d, md[d], mf[d]);
               end else begin
                  word_t w;
                  w = exp_q[d].pop_front();
                  check($sformatf("data_dut%0d", d), 64'(md[d]), 64'(w.data));
                  check($sformatf("fill_dut%0d", d), 64'(mf[d]), 64'(w.fill));
                  check($sformatf("last_dut%0d", d), 64'(ml[d]), 64'(w.last));
               end
               if (d == 0 && gap_mode) begin
                  if (last_acc >= 0) check("valid_period", 64'(cyc - last_acc), 64'd8);
                  last_acc = cyc;
               end
            end
            stall[d]     = mv[d] && !if_msb.m_ready_i;
            held[d].data = md[d];
            held[d].fill = mf[d];
            held[d].last = ml[d];
         end
      end
   end

   initial begin
      resetn           = 1'b0;
      if_msb.s_valid_i = 1'b0;
      if_msb.s_data_i  = '0;
      if_msb.s_last_i  = 1'b0;
      if_msb.m_ready_i = 1'b1;

      // Reset state
      apply_reset();

      // Full words, back-to-back, ready high
      send_byte(8'hA5, 1'b0);
      wait_drain();
      send_byte(8'hC0, 1'b0);
      wait_drain();

      // Short frame closed by last, then a fresh word from slot 0
      send_beat(1'b1, 1'b0);
      send_beat(1'b1, 1'b0);
      send_beat(1'b1, 1'b1);
      send_byte(8'h96, 1'b0);
      wait_drain();

      // Last on the final beat of a full word
      send_byte(8'h5A, 1'b1);
      wait_drain();

      // Backpressure: word held 10 cycles, next word queued behind it
      ready_val = 1'b0;
      send_byte(8'hA5, 1'b0);
      fork
         send_byte(8'h3C, 1'b0);
         begin
            repeat (10) begin
               @(negedge clk);
               check("stall_s_ready", 64'(if_msb.s_ready_o), 64'd0);
               check("stall_data",    64'(if_msb.m_data_o),  64'hA5);
            end
            ready_val = 1'b1;
         end
      join
      wait_drain();

      // 64 continuous random bits: one word every 8 cycles
      gap_mode = 1'b1;
      last_acc = -1;
      for (int i = 0; i < 64; i++) send_beat(IW'($urandom), 1'b0);
      wait_drain();
      gap_mode = 1'b0;

      // Reset mid-word drops the partial word
      for (int i = 0; i < 4; i++) send_beat(IW'($urandom), 1'b0);
      apply_reset();
      repeat (12) @(posedge clk);
      #1;
      send_byte(8'h81, 1'b0);
      wait_drain();

      // Random beats, random frame ends, random gaps and random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         send_beat(IW'($urandom), ($urandom_range(0, 4) == 0));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_rdy  = 1'b0;
      ready_val = 1'b1;
      wait_drain();
      check("final_pending_beats", 64'(cur.size() == RATIO), 64'd0);
      check("final_queue_msb", 64'(exp_q[0].size()), 64'd0);
      check("final_queue_lsb", 64'(exp_q[1].size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
